// File: rtl/panda_pkg.sv
// Shared constants and types for the panda core front end.
package panda_pkg;
  localparam logic [31:0] PANDA_BOOT_ADDR = 32'h0000_0000;
  localparam logic [31:0] FETCH_WIDTH     = 32'd4;

  typedef enum logic {IF_IDLE, IF_REQ} if_state_e;
endpackage

// File: rtl/panda_fifo.sv
// Generic synchronous FIFO with flush; flush takes priority over push/pop.
module panda_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = data_i;
        wptr_d        = ptr_inc(wptr_q);
      end
      if (do_pop) rptr_d = ptr_inc(rptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/panda_if_stage.sv
// Instruction fetch: owns the fetch PC, issues req/gnt/rvalid word fetches,
// buffers responses in a prefetch FIFO and handles redirects.
module panda_if_stage import panda_pkg::*; #(
  parameter logic [31:0] BOOT_ADDR = PANDA_BOOT_ADDR,
  parameter int          DEPTH     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_next_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i
);
  localparam int         CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  if_state_e     state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d, hold_addr_q, hold_addr_d, pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d;
  logic          stale_q, stale_d;
  logic          gnt, push, pop, issue_ok, fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count, count_nxt;
  logic [31:0]   target;

  assign target        = redirect_target_i & ~32'h3;
  assign instr_req_o   = (state_q == IF_REQ);
  // A request redirected before its grant keeps presenting the old address.
  assign instr_addr_o  = stale_q ? hold_addr_q : fetch_addr_q;
  assign instr_valid_o = ~fifo_empty;
  assign pc_o          = pc_q;
  assign pc_next_o     = pc_q + FETCH_WIDTH;

  always_comb begin
    gnt          = instr_req_o & instr_gnt_i;
    push         = instr_rvalid_i & (discard_q == '0) & ~redirect_i;
    pop          = ~fifo_empty & instr_ready_i & ~redirect_i;
    inflight_d   = inflight_q + CW'(gnt) - CW'(instr_rvalid_i);
    discard_d    = discard_q - CW'(instr_rvalid_i && discard_q != '0) + CW'(gnt && stale_q);
    fetch_addr_d = (gnt && !stale_q) ? fetch_addr_q + FETCH_WIDTH : fetch_addr_q;
    hold_addr_d  = hold_addr_q;
    stale_d      = stale_q & ~gnt;
    pc_d         = pop ? pc_q + FETCH_WIDTH : pc_q;
    count_nxt    = fifo_count + CW'(push) - CW'(pop);
    if (redirect_i) begin
      // Everything still outstanding after this cycle belongs to the old path.
      fetch_addr_d = target;
      pc_d         = target;
      discard_d    = inflight_d;
      count_nxt    = '0;
      if (instr_req_o && !gnt) begin
        stale_d = 1'b1;
        if (!stale_q) hold_addr_d = fetch_addr_q;
      end
    end
    issue_ok = fetch_enable_i & (({1'b0, inflight_d} + {1'b0, count_nxt}) < DEPTH_C);
    state_d  = state_q;
    case (state_q)
      IF_IDLE: if (issue_ok) state_d = IF_REQ;
      IF_REQ:  if (gnt && !issue_ok) state_d = IF_IDLE;
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IF_IDLE;
      fetch_addr_q <= BOOT_ADDR;
      hold_addr_q  <= BOOT_ADDR;
      pc_q         <= BOOT_ADDR;
      inflight_q   <= '0;
      discard_q    <= '0;
      stale_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      hold_addr_q  <= hold_addr_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      stale_q      <= stale_d;
    end
  end

  panda_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_i  (instr_rdata_i),
    .data_o  (instr_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));
endmodule

// File: tb/tb_panda_if_stage.sv
// Bench for panda_if_stage: bus memory model plus a scoreboard of expected PCs.
module tb_panda_if_stage;
  logic        clk = 1'b0, rst_n = 1'b0, fetch_enable = 1'b0, ready = 1'b0, redirect = 1'b0;
  logic        gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = 32'h0, target = 32'h0;
  logic        instr_req, instr_valid;
  logic [31:0] instr_addr, instr, pc, pc_next;

  int checks = 0, errors = 0, cyc = 0, first_gnt_cyc = -1;
  logic gnt_en = 1'b1, rvalid_en = 1'b1;
  logic [31:0] pend_q[$], gnt_log[$], exp_q[$];

  panda_if_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_enable_i(fetch_enable),
    .instr_req_o(instr_req), .instr_addr_o(instr_addr), .instr_gnt_i(gnt),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
    .instr_valid_o(instr_valid), .instr_o(instr), .pc_o(pc), .pc_next_o(pc_next),
    .instr_ready_i(ready), .redirect_i(redirect), .redirect_target_i(target)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Memory: grants when allowed, answers in order one cycle later (or when released).
  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      gnt = 1'b0; rvalid = 1'b0; pend_q.delete();
    end else begin
      if (rvalid_en && pend_q.size() > 0) begin
        rvalid = 1'b1; rdata = mem_f(pend_q.pop_front());
      end else begin
        rvalid = 1'b0; rdata = 32'hDEAD_BEEF;
      end
      gnt = instr_req & gnt_en;
      if (gnt) begin
        pend_q.push_back(instr_addr);
        gnt_log.push_back(instr_addr);
        if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
      end
    end
  end

  // Scoreboard: every accepted instruction must match the next expected PC.
  initial begin : mon
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && ready && !redirect) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected pc=%h instr=%h (no entry expected)", pc, instr);
        end else begin
          e = exp_q.pop_front();
          if (pc !== e || instr !== mem_f(e) || pc_next !== e + 32'd4) begin
            errors++;
            $display("FAIL sb_pop got pc=%h instr=%h pc_next=%h want pc=%h instr=%h pc_next=%h",
                     pc, instr, pc_next, e, mem_f(e), e + 32'd4);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic apply_reset();
    rst_n = 1'b0; fetch_enable = 1'b0; ready = 1'b0; redirect = 1'b0; target = 32'h0;
    gnt_en = 1'b1; rvalid_en = 1'b1;
    exp_q.delete(); gnt_log.delete(); first_gnt_cyc = -1;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_drain(input int budget);
    ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks += 6;
    if (instr_req !== 1'b0)          begin errors++; $display("FAIL rst_req got %b want 0", instr_req); end
    if (instr_addr !== 32'h0)        begin errors++; $display("FAIL rst_addr got %h want 0", instr_addr); end
    if (instr_valid !== 1'b0)        begin errors++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    if (instr !== 32'h0)             begin errors++; $display("FAIL rst_instr got %h want 0", instr); end
    if (pc !== 32'h0)                begin errors++; $display("FAIL rst_pc got %h want 0", pc); end
    if (pc_next !== 32'h4)           begin errors++; $display("FAIL rst_pc_next got %h want 4", pc_next); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (instr_req !== 1'b0) begin errors++; $display("FAIL idle_no_enable req got %b want 0", instr_req); end
  endtask

  task automatic test_stream();
    int first_valid_cyc;
    apply_reset();
    first_valid_cyc = -1;
    push_exp(32'h0, 12);
    ready = 1'b1; fetch_enable = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      tick();
      if (instr_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    ready = 1'b0;
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain left %0d want 0", exp_q.size()); end
    if (first_valid_cyc - first_gnt_cyc != 2)
      begin errors++; $display("FAIL stream_latency got %0d want 2", first_valid_cyc - first_gnt_cyc); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (gnt_log.size() <= i || gnt_log[i] !== 32'(4 * i))
        begin errors++; $display("FAIL stream_addr[%0d] got %h want %h", i, (gnt_log.size() > i) ? gnt_log[i] : 32'hX, 32'(4 * i)); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    fetch_enable = 1'b1;
    repeat (8) tick();
    checks += 5;
    if (instr_req !== 1'b0)     begin errors++; $display("FAIL bp_req got %b want 0", instr_req); end
    if (instr_addr !== 32'h8)   begin errors++; $display("FAIL bp_addr got %h want 8", instr_addr); end
    if (instr_valid !== 1'b1)   begin errors++; $display("FAIL bp_valid got %b want 1", instr_valid); end
    if (pc !== 32'h0)           begin errors++; $display("FAIL bp_pc got %h want 0", pc); end
    if (gnt_log.size() != 2)    begin errors++; $display("FAIL bp_grants got %0d want 2", gnt_log.size()); end
    push_exp(32'h0, 4);
    wait_drain(50);
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain left %0d want 0", exp_q.size()); end
    if (gnt_log.size() < 3 || gnt_log[2] !== 32'h8)
      begin errors++; $display("FAIL bp_resume third grant missing or not at 8 (grants %0d)", gnt_log.size()); end
  endtask

  task automatic test_gnt_stall();
    apply_reset();
    push_exp(32'h0, 8);
    ready = 1'b1; fetch_enable = 1'b1;
    for (int i = 0; i < 40 && !(instr_req === 1'b1 && instr_addr === 32'h10); i++) tick();
    checks++;
    if (!(instr_req === 1'b1 && instr_addr === 32'h10))
      begin errors++; $display("FAIL stall_reach req=%b addr=%h want req at 10", instr_req, instr_addr); end
    gnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_req !== 1'b1 || instr_addr !== 32'h10)
        begin errors++; $display("FAIL stall_hold[%0d] req=%b addr=%h want 1/10", i, instr_req, instr_addr); end
    end
    gnt_en = 1'b1;
    tick();
    checks++;
    if (instr_addr !== 32'h14) begin errors++; $display("FAIL stall_advance addr got %h want 14", instr_addr); end
    wait_drain(60);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    apply_reset();
    fetch_enable = 1'b1;
    for (int i = 0; i < 10 && instr_valid !== 1'b1; i++) tick();
    // One entry buffered, one response still outstanding: hold it back.
    rvalid_en = 1'b0; redirect = 1'b1; target = 32'h40; exp_q.delete();
    tick();
    redirect = 1'b0;
    checks += 3;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush valid got %b want 0", instr_valid); end
    if (pc !== 32'h40)        begin errors++; $display("FAIL redir_pc got %h want 40", pc); end
    if (pc_next !== 32'h44)   begin errors++; $display("FAIL redir_pc_next got %h want 44", pc_next); end
    rvalid_en = 1'b1;
    push_exp(32'h40, 3);
    wait_drain(60);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL redir_drain left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_unaligned();
    apply_reset();
    fetch_enable = 1'b1;
    repeat (5) tick();
    redirect = 1'b1; target = 32'h42;
    tick();
    redirect = 1'b0;
    checks += 2;
    if (pc !== 32'h40)         begin errors++; $display("FAIL unal_pc got %h want 40", pc); end
    if (instr_addr !== 32'h40) begin errors++; $display("FAIL unal_addr got %h want 40", instr_addr); end
    push_exp(32'h40, 2);
    wait_drain(40);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL unal_drain left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_collide();
    apply_reset();
    push_exp(32'h0, 16);
    ready = 1'b1; fetch_enable = 1'b1;
    for (int i = 0; i < 40 && !(instr_valid === 1'b1 && pend_q.size() > 0 && gnt_log.size() >= 4); i++) tick();
    // Pop, rvalid and redirect all land in this cycle.
    redirect = 1'b1; target = 32'h80; exp_q.delete();
    tick();
    redirect = 1'b0;
    checks += 2;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL coll_valid got %b want 0", instr_valid); end
    if (pc !== 32'h80)        begin errors++; $display("FAIL coll_pc got %h want 80", pc); end
    push_exp(32'h80, 3);
    wait_drain(60);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL coll_drain left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_pending();
    apply_reset();
    gnt_en = 1'b0; fetch_enable = 1'b1;
    for (int i = 0; i < 5 && instr_req !== 1'b1; i++) tick();
    redirect = 1'b1; target = 32'h100;
    tick();
    redirect = 1'b0;
    tick();
    checks += 2;
    if (instr_req !== 1'b1)  begin errors++; $display("FAIL pend_req got %b want 1", instr_req); end
    if (instr_addr !== 32'h0) begin errors++; $display("FAIL pend_hold addr got %h want 0", instr_addr); end
    gnt_en = 1'b1;
    tick();
    checks++;
    if (instr_addr !== 32'h100) begin errors++; $display("FAIL pend_resume addr got %h want 100", instr_addr); end
    push_exp(32'h100, 2);
    wait_drain(40);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL pend_drain left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    apply_reset();
    fetch_enable = 1'b1; redirect = 1'b1; target = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    push_exp(32'hFFFF_FFF8, 4);
    wait_drain(60);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    push_exp(32'h0, 16);
    ready = 1'b1; fetch_enable = 1'b1;
    repeat (10) tick();
    rst_n = 1'b0; exp_q.delete(); gnt_log.delete();
    #1;
    checks += 3;
    if (instr_req !== 1'b0)   begin errors++; $display("FAIL arst_req got %b want 0", instr_req); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", instr_valid); end
    if (pc !== 32'h0)         begin errors++; $display("FAIL arst_pc got %h want 0", pc); end
    rst_n = 1'b1;
    push_exp(32'h0, 4);
    wait_drain(60);
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL arst_drain left %0d want 0", exp_q.size()); end
    if (gnt_log.size() == 0 || gnt_log[0] !== 32'h0)
      begin errors++; $display("FAIL arst_restart first grant not at boot address (grants %0d)", gnt_log.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_stall();
    test_redirect();
    test_unaligned();
    test_collide();
    test_redirect_pending();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
